piu_pchlist_buf: RTL

//  Upstream feeder of the per-patch info lookup in the PIU. Collects per-patch (opcode, mreg, pauli) write beats of one

---
 rtl/piu_pchlist_buf_if.sv | 40 ++++
 rtl/piu_pchlist_buf.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/piu_pchlist_buf_if.sv
// Write-beat channel and committed per-patch list bus between the instruction
// decoder (master) and the double-buffered patch list (slave).
interface piu_pchlist_buf_if #(
    parameter int NUM_PCH    = 16,
    parameter int PCHADDR_BW = 4,
    parameter int OPCODE_BW  = 4,
    parameter int LQADDR_BW  = 4
);
    logic                          wr_valid;
    logic                          wr_ready;
    logic [PCHADDR_BW-1:0]         wr_pchidx;
    logic [OPCODE_BW-1:0]          wr_opcode;
    logic [LQADDR_BW-1:0]          wr_mreg;
    logic [1:0]                    wr_pp;
    logic                          wr_last;
    logic [OPCODE_BW-1:0]          wr_inst_opcode;

    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_PCH*OPCODE_BW-1:0]  pchop_list_reg0;
    logic [NUM_PCH*OPCODE_BW-1:0]  pchop_list_reg1;
    logic [NUM_PCH*LQADDR_BW-1:0]  pchmreg_list_reg0;
    logic [NUM_PCH*LQADDR_BW-1:0]  pchmreg_list_reg1;
    logic [NUM_PCH*2-1:0]          pchpp_list_reg0;
    logic [NUM_PCH*2-1:0]          pchpp_list_reg1;
    logic [OPCODE_BW-1:0]          opcode_reg;
    logic                          err_overflow;

    modport master (
        output wr_valid, wr_pchidx, wr_opcode, wr_mreg, wr_pp, wr_last, wr_inst_opcode, out_ready,
        input  wr_ready, out_valid, pchop_list_reg0, pchop_list_reg1, pchmreg_list_reg0,
               pchmreg_list_reg1, pchpp_list_reg0, pchpp_list_reg1, opcode_reg, err_overflow
    );

    modport slave (
        input  wr_valid, wr_pchidx, wr_opcode, wr_mreg, wr_pp, wr_last, wr_inst_opcode, out_ready,
        output wr_ready, out_valid, pchop_list_reg0, pchop_list_reg1, pchmreg_list_reg0,
               pchmreg_list_reg1, pchpp_list_reg0, pchpp_list_reg1, opcode_reg, err_overflow
    );
endinterface

// File: rtl/piu_pchlist_buf.sv
// Double-buffered per-patch instruction list: beats build a two-slot-per-patch
// bank that is committed into a registered output bank on the instruction's last beat.
module piu_pchlist_buf #(
    parameter int NUM_PCH        = 16,
    parameter int PCHADDR_BW     = 4,
    parameter int OPCODE_BW      = 4,
    parameter int LQADDR_BW      = 4,
    parameter int INVALID_OPCODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    piu_pchlist_buf_if.slave  bus
);
    localparam logic [OPCODE_BW-1:0] INV_OP = OPCODE_BW'(INVALID_OPCODE);

    typedef enum logic {S_FILL, S_PEND} state_t;

    typedef logic [NUM_PCH-1:0][OPCODE_BW-1:0] op_arr_t;
    typedef logic [NUM_PCH-1:0][LQADDR_BW-1:0] mreg_arr_t;
    typedef logic [NUM_PCH-1:0][1:0]           pp_arr_t;

    state_t                 state_q, state_d;
    logic [NUM_PCH-1:0][1:0] cnt_q, cnt_d, wcnt;
    op_arr_t                bop0_q, bop1_q, bop0_d, bop1_d, wop0, wop1;
    mreg_arr_t              bmreg0_q, bmreg1_q, bmreg0_d, bmreg1_d, wmreg0, wmreg1;
    pp_arr_t                bpp0_q, bpp1_q, bpp0_d, bpp1_d, wpp0, wpp1;
    op_arr_t                op0_q, op1_q, op0_d, op1_d;
    mreg_arr_t              mreg0_q, mreg1_q, mreg0_d, mreg1_d;
    pp_arr_t                pp0_q, pp1_q, pp0_d, pp1_d;
    logic [OPCODE_BW-1:0]   opcode_q, opcode_d, inst_op_q, inst_op_d, commit_op;
    logic                   out_valid_q, out_valid_d, err_q, err_d;
    logic                   wr_ready, accept, bank_free, commit, go_pend, ovf, idx_ok;

    generate
        if (NUM_PCH == (1 << PCHADDR_BW)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_chk
            assign idx_ok = {1'b0, bus.wr_pchidx} < (PCHADDR_BW+1)'(NUM_PCH);
        end
    endgenerate

    assign accept    = bus.wr_valid & wr_ready;
    assign bank_free = ~out_valid_q | bus.out_ready;
    assign go_pend   = accept & bus.wr_last & ~bank_free;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FILL;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (go_pend)   state_d = S_PEND;
            S_PEND:  if (bank_free) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // FSM: outputs
    always_comb begin
        wr_ready  = 1'b0;
        commit    = 1'b0;
        commit_op = inst_op_q;
        case (state_q)
            S_FILL: begin
                wr_ready  = 1'b1;
                commit    = accept & bus.wr_last & bank_free;
                commit_op = bus.wr_inst_opcode;
            end
            S_PEND:  commit = bank_free;
            default: ;
        endcase
    end

    // Build bank with the current beat merged in; feeds both the bank and a bypass commit.
    always_comb begin
        wop0 = bop0_q;  wop1 = bop1_q;
        wmreg0 = bmreg0_q;  wmreg1 = bmreg1_q;
        wpp0 = bpp0_q;  wpp1 = bpp1_q;
        wcnt = cnt_q;
        ovf  = 1'b0;
        if (accept) begin
            if (!idx_ok) begin
                ovf = 1'b1;
            end else begin
                case (cnt_q[bus.wr_pchidx])
                    2'd0: begin
                        wop0[bus.wr_pchidx]   = bus.wr_opcode;
                        wmreg0[bus.wr_pchidx] = bus.wr_mreg;
                        wpp0[bus.wr_pchidx]   = bus.wr_pp;
                        wcnt[bus.wr_pchidx]   = 2'd1;
                    end
                    2'd1: begin
                        wop1[bus.wr_pchidx]   = bus.wr_opcode;
                        wmreg1[bus.wr_pchidx] = bus.wr_mreg;
                        wpp1[bus.wr_pchidx]   = bus.wr_pp;
                        wcnt[bus.wr_pchidx]   = 2'd2;
                    end
                    default: ovf = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        bop0_d = wop0;  bop1_d = wop1;
        bmreg0_d = wmreg0;  bmreg1_d = wmreg1;
        bpp0_d = wpp0;  bpp1_d = wpp1;
        cnt_d  = wcnt;
        op0_d = op0_q;  op1_d = op1_q;
        mreg0_d = mreg0_q;  mreg1_d = mreg1_q;
        pp0_d = pp0_q;  pp1_d = pp1_q;
        opcode_d    = opcode_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        inst_op_d   = go_pend ? bus.wr_inst_opcode : inst_op_q;
        err_d       = err_q | ovf;
        if (commit) begin
            op0_d = wop0;  op1_d = wop1;
            mreg0_d = wmreg0;  mreg1_d = wmreg1;
            pp0_d = wpp0;  pp1_d = wpp1;
            opcode_d    = commit_op;
            out_valid_d = 1'b1;
            bop0_d = {NUM_PCH{INV_OP}};  bop1_d = {NUM_PCH{INV_OP}};
            bmreg0_d = '0;  bmreg1_d = '0;
            bpp0_d = '0;  bpp1_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bop0_q <= {NUM_PCH{INV_OP}};  bop1_q <= {NUM_PCH{INV_OP}};
            bmreg0_q <= '0;  bmreg1_q <= '0;
            bpp0_q <= '0;  bpp1_q <= '0;
            cnt_q  <= '0;
            op0_q <= {NUM_PCH{INV_OP}};  op1_q <= {NUM_PCH{INV_OP}};
            mreg0_q <= '0;  mreg1_q <= '0;
            pp0_q <= '0;  pp1_q <= '0;
            opcode_q    <= INV_OP;
            inst_op_q   <= INV_OP;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bop0_q <= bop0_d;  bop1_q <= bop1_d;
            bmreg0_q <= bmreg0_d;  bmreg1_q <= bmreg1_d;
            bpp0_q <= bpp0_d;  bpp1_q <= bpp1_d;
            cnt_q  <= cnt_d;
            op0_q <= op0_d;  op1_q <= op1_d;
            mreg0_q <= mreg0_d;  mreg1_q <= mreg1_d;
            pp0_q <= pp0_d;  pp1_q <= pp1_d;
            opcode_q    <= opcode_d;
            inst_op_q   <= inst_op_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.wr_ready          = wr_ready;
    assign bus.out_valid         = out_valid_q;
    assign bus.pchop_list_reg0   = op0_q;
    assign bus.pchop_list_reg1   = op1_q;
    assign bus.pchmreg_list_reg0 = mreg0_q;
    assign bus.pchmreg_list_reg1 = mreg1_q;
    assign bus.pchpp_list_reg0   = pp0_q;
    assign bus.pchpp_list_reg1   = pp1_q;
    assign bus.opcode_reg        = opcode_q;
    assign bus.err_overflow      = err_q;
endmodule
